crd_hold: RTL and testbench
===========================

Name: crd_hold

Overview:
- Sparse-pipeline coordinate-hold primitive.
- Takes an inner coordinate stream (port 0) and an outer coordinate stream (port 1).
- Re-emits the inner stream unchanged and, in lock-step on output 1, repeats the current outer coordinate once per inner token.
- Sits after level scanners and feeds intersect/union or writer blocks; all ports are 17-bit ready/valid streams.

Parameters:
- DATA_W, 16, payload width; each token is DATA_W+1 bits wide.
- FIFO_DEPTH, 2, depth of each output FIFO.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high despite the legacy name; clears all state
- clk_en  in  1  global clock enable; when low, no state changes
- tile_en  in  1  when low, block is idle: all readies 0, all valids 0
- flush  in  1  synchronous clear of FSM and FIFOs, same effect as reset
- cmrg_enable  in  1  reserved, ignored
- cmrg_stop_lvl  in  16  reserved, ignored
- cmrg_coord_in_0 / _valid / _ready  in/in/out  17/1/1  inner coordinate stream
- cmrg_coord_in_1 / _valid / _ready  in/in/out  17/1/1  outer coordinate stream
- cmrg_coord_out_0 / _valid / _ready  out/out/in  17/1/1  inner passthrough
- cmrg_coord_out_1 / _valid / _ready  out/out/in  17/1/1  held outer coordinate

Behaviour:
- Token encoding:
  - bit16=0: data token, bits[15:0] = coordinate.
  - bit16=1, bits[9:8]=2'b00: stop token S_k, k = bits[7:0].
  - bit16=1, bits[9:8]=2'b01: done token D (17'h10100).
- Reset/flush values:
  - FSM = RUN; FIFOs empty.
  - out valids 0; in readies 0 until FIFOs are known non-full.
- Outputs come from two FIFO_DEPTH-deep FIFOs.
  - Latency is 1 cycle from input handshake to output valid.
  - Throughput is 1 token/cycle when downstream is ready.
- fire = tile_en & clk_en & in0_valid & in1_valid & !full0 & !full1 & state==RUN.
  - Both FIFOs are pushed together, so outputs stay token-aligned.
- RUN, per inner head token (outer head must be a data token or D):
  - Inner data c, outer head data o: push c to out0, o to out1; pop inner only.
  - Inner S0: push S0 to both outputs; pop inner and outer. Covers empty inner fibers.
  - Inner S_k, k>=1: push S_k to both outputs; pop inner and outer; go to DROP.
  - Inner D and outer D: push D to both outputs; pop both; go to DONE.
- DROP:
  - Wait for in1_valid, then consume and discard the outer stop S_(k-1) without pushing anything.
  - Return to RUN.
  - No inner token is consumed in DROP.
- DONE: for one cycle, wait for both FIFOs to drain, then return to RUN for the next tile.
- Malformed input stalls the block (no pop, no push) until flush or reset:
  - outer head is a stop token in RUN;
  - D arrives on only one input.
- in0_ready is asserted only on cycles where inner is popped; likewise in1_ready for outer (data pop or DROP discard).
- Output FIFO full: no fire, upstream backpressured; no token is lost or duplicated.
- Simultaneous push and pop on a full FIFO is allowed.
- Reset or flush mid-stream discards FIFO contents and pending DROP.

Decomposition:
- Shared package sparse_tok_pkg holds:
  - token width;
  - field positions (CTRL_BIT=16, TYPE bits 9:8, LVL bits 7:0);
  - constants TOK_DONE=17'h10100, TOK_S0=17'h10000;
  - helper functions is_stop, is_done, stop_lvl.
- One sub-module: tok_fifo, a parameterised ready/valid FIFO, instantiated twice.

Test Plan:
- Basic:
  - Stimulus: inner [1,3,S0,0,S1,D], outer [0,2,S0,D].
  - Required: out0 = inner stream unchanged; out1 = [0,0,S0,2,S1,D].
- Empty inner fiber:
  - Stimulus: inner [S0,5,S1,D], outer [4,7,S0,D].
  - Required: out0 = [S0,5,S1,D]; out1 = [S0,7,S1,D].
- Backpressure:
  - Stimulus: basic streams, random ready on outputs and random valid gaps on inputs.
  - Required: same sequences as basic, no drops or duplicates.
  - Required: with ready held at 1, cycles from first input valid to done on both outputs are at most tokens + 3.
- Deep stop:
  - Stimulus: inner [1,S0,2,S2,D], outer [3,4,S1,D].
  - Required: out1 = [3,S0,4,S2,D]; outer S1 is consumed and discarded.
- Flush mid-stream:
  - Stimulus: pulse flush after 2 tokens, then replay the basic streams.
  - Required: outputs exactly as basic; valids 0 during and right after flush.
- tile_en=0:
  - Stimulus: hold tile_en low with valid inputs presented.
  - Required: all readies and valids stay 0.

Source files
------------

// File: rtl/sparse_tok_pkg.sv
// Token layout shared by the sparse-stream primitives: field positions,
// well-known control tokens and small classification helpers.
package sparse_tok_pkg;

    localparam int TOK_W    = 17;
    localparam int CTRL_BIT = 16;
    localparam int TYPE_HI  = 9;
    localparam int TYPE_LO  = 8;
    localparam int LVL_HI   = 7;
    localparam int LVL_LO   = 0;
    localparam int LVL_W    = LVL_HI - LVL_LO + 1;

    localparam logic [1:0] TYPE_STOP = 2'b00;
    localparam logic [1:0] TYPE_DONE = 2'b01;

    localparam logic [TOK_W-1:0] TOK_DONE = 17'h10100;
    localparam logic [TOK_W-1:0] TOK_S0   = 17'h10000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DROP = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } hold_state_e;

    // Helpers take the control bit and the low field bits separately so they
    // work for any payload width that keeps the type/level fields in place.
    function automatic logic is_stop(input logic ctrl, input logic [TYPE_HI:0] low);
        return ctrl && (low[TYPE_HI:TYPE_LO] == TYPE_STOP);
    endfunction

    function automatic logic is_done(input logic ctrl, input logic [TYPE_HI:0] low);
        return ctrl && (low[TYPE_HI:TYPE_LO] == TYPE_DONE);
    endfunction

    function automatic logic [LVL_W-1:0] stop_lvl(input logic [TYPE_HI:0] low);
        return low[LVL_HI:LVL_LO];
    endfunction

endpackage

// File: rtl/tok_fifo.sv
// Small synchronous ready/valid FIFO; push and pop may coincide even when full.
module tok_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? next_ptr(wr_q) : wr_q;
        rd_d  = do_pop ? next_ptr(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries data only; validity is tracked by the count above.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/crd_hold.sv
// Coordinate hold: passes the inner stream through and repeats the current
// outer coordinate once per inner token, both outputs kept token-aligned.
module crd_hold
    import sparse_tok_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              tile_en,
    input  logic              flush,
    input  logic              cmrg_enable,
    input  logic [15:0]       cmrg_stop_lvl,
    input  logic [DATA_W:0]   cmrg_coord_in_0,
    input  logic              cmrg_coord_in_0_valid,
    output logic              cmrg_coord_in_0_ready,
    input  logic [DATA_W:0]   cmrg_coord_in_1,
    input  logic              cmrg_coord_in_1_valid,
    output logic              cmrg_coord_in_1_ready,
    output logic [DATA_W:0]   cmrg_coord_out_0,
    output logic              cmrg_coord_out_0_valid,
    input  logic              cmrg_coord_out_0_ready,
    output logic [DATA_W:0]   cmrg_coord_out_1,
    output logic              cmrg_coord_out_1_valid,
    input  logic              cmrg_coord_out_1_ready
);

    localparam int TW = DATA_W + 1;

    logic unused_cfg;
    assign unused_cfg = ^{cmrg_enable, cmrg_stop_lvl};

    hold_state_e      state_q, state_d;
    logic             act;
    logic             full0, full1, empty0, empty1;
    logic             push, pop0, pop1;
    logic [TW-1:0]    wr1_data;
    logic             in0_data, in0_stop, in0_done;
    logic             in1_data, in1_done;
    logic [LVL_W-1:0] in0_lvl;
    logic             malformed;

    // Reset is folded in so no upstream handshake is offered while held.
    assign act = tile_en & clk_en & ~flush & ~rst_n;

    assign in0_data = ~cmrg_coord_in_0[DATA_W];
    assign in0_stop = is_stop(cmrg_coord_in_0[DATA_W], cmrg_coord_in_0[TYPE_HI:0]);
    assign in0_done = is_done(cmrg_coord_in_0[DATA_W], cmrg_coord_in_0[TYPE_HI:0]);
    assign in0_lvl  = stop_lvl(cmrg_coord_in_0[TYPE_HI:0]);
    assign in1_data = ~cmrg_coord_in_1[DATA_W];
    assign in1_done = is_done(cmrg_coord_in_1[DATA_W], cmrg_coord_in_1[TYPE_HI:0]);

    always_comb begin
        malformed = 1'b0;
        if (!in1_data && !in1_done) begin
            malformed = 1'b1;
        end else if (in0_data || in0_stop) begin
            malformed = in1_done;
        end else if (in0_done) begin
            malformed = ~in1_done;
        end else begin
            malformed = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        pop0     = 1'b0;
        pop1     = 1'b0;
        wr1_data = cmrg_coord_in_0;
        case (state_q)
            ST_RUN: begin
                if (act && cmrg_coord_in_0_valid && cmrg_coord_in_1_valid) begin
                    if (malformed) begin
                        state_d = ST_ERR;
                    end else if (!full0 && !full1) begin
                        push = 1'b1;
                        pop0 = 1'b1;
                        if (in0_data) begin
                            wr1_data = cmrg_coord_in_1;
                        end else begin
                            pop1 = 1'b1;
                            if (in0_done) begin
                                state_d = ST_DONE;
                            end else if (in0_lvl != '0) begin
                                state_d = ST_DROP;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (act && cmrg_coord_in_1_valid) begin
                    pop1    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (act && empty0 && empty1) begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_RUN;
        end else if (flush) begin
            state_q <= ST_RUN;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    assign cmrg_coord_in_0_ready  = pop0;
    assign cmrg_coord_in_1_ready  = pop1;
    assign cmrg_coord_out_0_valid = act & ~empty0;
    assign cmrg_coord_out_1_valid = act & ~empty1;

    tok_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .clr_i   (flush),
        .push_i  (push),
        .data_i  (cmrg_coord_in_0),
        .pop_i   (cmrg_coord_out_0_valid & cmrg_coord_out_0_ready),
        .data_o  (cmrg_coord_out_0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    tok_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .clr_i   (flush),
        .push_i  (push),
        .data_i  (wr1_data),
        .pop_i   (cmrg_coord_out_1_valid & cmrg_coord_out_1_ready),
        .data_o  (cmrg_coord_out_1),
        .full_o  (full1),
        .empty_o (empty1)
    );

endmodule

// File: tb/tb_crd_hold.sv
// Randomised bench for crd_hold against a list-level coordinate-hold model.
module tb_crd_hold;

    typedef logic [16:0] tq_t[$];

    localparam logic [16:0] TD = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, tile_en, flush, cmrg_enable;
    logic [15:0] cmrg_stop_lvl;
    logic [16:0] in0, in1, out0, out1;
    logic        in0_v, in0_r, in1_v, in1_r, out0_v, out0_r, out1_v, out1_r;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    crd_hold #(.DATA_W(16), .FIFO_DEPTH(2)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .clk_en                 (clk_en),
        .tile_en                (tile_en),
        .flush                  (flush),
        .cmrg_enable            (cmrg_enable),
        .cmrg_stop_lvl          (cmrg_stop_lvl),
        .cmrg_coord_in_0        (in0),
        .cmrg_coord_in_0_valid  (in0_v),
        .cmrg_coord_in_0_ready  (in0_r),
        .cmrg_coord_in_1        (in1),
        .cmrg_coord_in_1_valid  (in1_v),
        .cmrg_coord_in_1_ready  (in1_r),
        .cmrg_coord_out_0       (out0),
        .cmrg_coord_out_0_valid (out0_v),
        .cmrg_coord_out_0_ready (out0_r),
        .cmrg_coord_out_1       (out1),
        .cmrg_coord_out_1_valid (out1_v),
        .cmrg_coord_out_1_ready (out1_r)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] stp(input int k);
        return 17'h10000 | 17'(k);
    endfunction

    function automatic logic [16:0] dat(input int c);
        return {1'b0, 16'(c)};
    endfunction

    // Walk the inner stream; each stop closes one outer coordinate, and a
    // stop of level k>=1 additionally swallows the outer stop that follows.
    function automatic tq_t model_out1(input tq_t inn, input tq_t outr);
        tq_t e;
        int  j = 0;
        foreach (inn[i]) begin
            logic [16:0] t = inn[i];
            if (!t[16]) begin
                e.push_back(j < outr.size() ? outr[j] : 17'h1ffff);
            end else if (t == TD) begin
                e.push_back(TD);
                j++;
            end else begin
                e.push_back(t);
                j += (t[7:0] == 8'd0) ? 1 : 2;
            end
        end
        return e;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_en = 1'b1; tile_en = 1'b1; flush = 1'b0;
            in0_v = 1'b0; in1_v = 1'b0; out0_r = 1'b1; out1_r = 1'b1;
        end
    endtask

    task automatic run(input string nm, input tq_t inn, input tq_t outr, input bit rnd,
                       input int flush_at, output int cyc, output int first_cyc);
        tq_t e1, g0, g1;
        int  ia, oa, n;
        bit  p0, p1, done, flushed;
        e1 = model_out1(inn, outr);
        ia = 0; oa = 0; p0 = 0; p1 = 0; done = 0; flushed = 0;
        cyc = 0; first_cyc = -1;
        while (!done) begin
            @(negedge clk);
            flush   = 1'b0;
            clk_en  = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            tile_en = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
            if (!p0 && ia < inn.size())  p0 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!p1 && oa < outr.size()) p1 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            in0_v  = p0;
            in1_v  = p1;
            in0    = p0 ? inn[ia] : 17'($urandom);
            in1    = p1 ? outr[oa] : 17'($urandom);
            out0_r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out1_r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cyc++;
            if (!tile_en) begin
                check_eq({nm, " tile_en0 idle"}, {28'd0, in0_r, in1_r, out0_v, out1_v}, 32'd0);
            end
            if (in0_v && in0_r) begin ia++; p0 = 0; end
            if (in1_v && in1_r) begin oa++; p1 = 0; end
            if (out0_v && out0_r) begin
                g0.push_back(out0);
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (out1_v && out1_r) g1.push_back(out1);
            if (g0.size() >= inn.size() && g1.size() >= inn.size()) done = 1;
            if (flush_at >= 0 && ia == flush_at && !done) begin
                @(negedge clk);
                flush = 1'b1; in0_v = 1'b0; in1_v = 1'b0; tile_en = 1'b1; clk_en = 1'b1;
                #1;
                check_eq({nm, " valids in flush"}, {30'd0, out0_v, out1_v}, 32'd0);
                @(negedge clk);
                flush = 1'b0;
                #1;
                check_eq({nm, " valids after flush"}, {30'd0, out0_v, out1_v}, 32'd0);
                flushed = 1; done = 1;
            end
            if (cyc > 3000 && !done) begin
                check_eq({nm, " timeout"}, 32'(g0.size()), 32'(inn.size()));
                done = 1;
            end
        end
        in0_v = 1'b0; in1_v = 1'b0;
        if (!flushed) begin
            check_eq({nm, " out0 len"}, 32'(g0.size()), 32'(inn.size()));
            check_eq({nm, " out1 len"}, 32'(g1.size()), 32'(e1.size()));
            check_eq({nm, " outer consumed"}, 32'(oa), 32'(outr.size()));
            n = (g0.size() < inn.size()) ? g0.size() : inn.size();
            for (int i = 0; i < n; i++)
                check_eq($sformatf("%s out0[%0d]", nm, i), 32'(g0[i]), 32'(inn[i]));
            n = (g1.size() < e1.size()) ? g1.size() : e1.size();
            for (int i = 0; i < n; i++)
                check_eq($sformatf("%s out1[%0d]", nm, i), 32'(g1[i]), 32'(e1[i]));
        end
    endtask

    task automatic gen(output tq_t inn, output tq_t outr);
        int n, m, fl;
        inn.delete(); outr.delete();
        n = $urandom_range(1, 4);
        m = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            outr.push_back(dat($urandom_range(0, 65535)));
            fl = $urandom_range(0, 3);
            for (int f = 0; f < fl; f++) inn.push_back(dat($urandom_range(0, 65535)));
            inn.push_back((i == n - 1) ? stp(m + 1) : stp(0));
        end
        outr.push_back(stp(m));
        outr.push_back(TD);
        inn.push_back(TD);
    endtask

    initial begin
        tq_t b_in, b_out, a_in, a_out;
        int  cyc, fc;
        cmrg_enable = 1'b0; cmrg_stop_lvl = 16'd0;
        rst_n = 1'b1; clk_en = 1'b1; tile_en = 1'b1; flush = 1'b0;
        in0 = dat(9); in1 = dat(8); in0_v = 1'b1; in1_v = 1'b1; out0_r = 1'b1; out1_r = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset readies", {30'd0, in0_r, in1_r}, 32'd0);
        check_eq("reset valids", {30'd0, out0_v, out1_v}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0; in0_v = 1'b0; in1_v = 1'b0;
        #1;
        check_eq("post-reset valids", {30'd0, out0_v, out1_v}, 32'd0);

        // tile_en low with tokens offered: nothing moves
        tile_en = 1'b0; in0_v = 1'b1; in1_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_eq("tile_en0 rdy/vld", {28'd0, in0_r, in1_r, out0_v, out1_v}, 32'd0);
        end
        idle(2);

        b_in  = '{dat(1), dat(3), stp(0), dat(0), stp(1), TD};
        b_out = '{dat(0), dat(2), stp(0), TD};
        run("basic", b_in, b_out, 1'b0, -1, cyc, fc);
        check_eq("basic latency", 32'(fc), 32'd2);
        check_eq("basic cycles<=tok+3", {31'd0, cyc <= b_in.size() + 3}, 32'd1);
        idle(3);

        a_in  = '{stp(0), dat(5), stp(1), TD};
        a_out = '{dat(4), dat(7), stp(0), TD};
        run("empty_fiber", a_in, a_out, 1'b0, -1, cyc, fc);
        idle(3);

        a_in  = '{dat(1), stp(0), dat(2), stp(2), TD};
        a_out = '{dat(3), dat(4), stp(1), TD};
        run("deep_stop", a_in, a_out, 1'b0, -1, cyc, fc);
        idle(3);

        for (int r = 0; r < 4; r++) begin
            run("backpressure", b_in, b_out, 1'b1, -1, cyc, fc);
            idle(3);
        end

        run("flush2", b_in, b_out, 1'b0, 2, cyc, fc);
        run("replay2", b_in, b_out, 1'b0, -1, cyc, fc);
        idle(3);
        run("flush_drop", b_in, b_out, 1'b0, 5, cyc, fc);
        run("replay5", b_in, b_out, 1'b0, -1, cyc, fc);
        idle(3);

        for (int r = 0; r < 25; r++) begin
            gen(a_in, a_out);
            run($sformatf("rand%0d", r), a_in, a_out, 1'b1, -1, cyc, fc);
            idle(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
